lsu_mem_ctrl: RTL and testbench

Load/store memory-access controller between the execute stage and the single-port data memory. It accepts one load or store per transaction and generates the word-aligned address, byte enables and lane-shifted store data. It runs the request/grant/read-valid handshake with memory, then sign/zero-extends returned load data. It stalls the pipeline while a transaction is in flight and reports misaligned, illegal and timed-out accesses.

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_lane_align.sv | 55 +++++
 rtl/lsu_mem_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store memory-access controller.
//   - RISC-V memory opcodes (load / store)
//   - func3 access-size encodings
//   - controller state enum
//   - decode helpers for func3 legality and address alignment
package lsu_pkg;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE
   } lsu_state_t;

   // Stores have no unsigned variants, so only B/H/W are legal for them.
   function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
      logic ok;
      ok = 1'b0;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         F3_BU, F3_HU:     ok = !is_store;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   // func3[1:0] carries the access size for every legal encoding.
   function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] a);
      logic ok;
      case (f3[1:0])
         2'b00:   ok = 1'b1;
         2'b01:   ok = (a[0] == 1'b0);
         default: ok = (a == 2'b00);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering for the LSU.
//   func3_i   access size/sign
//   addr_lo_i byte offset within the word
//   wdata_i   unshifted store data (rs2)
//   rdata_i   word returned by memory
//   be_o      byte enables for the access
//   wdata_o   store data replicated across all lanes
//   rdata_o   selected lane, sign- or zero-extended to 32 bits
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  func3_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o
);

   logic [31:0] lane;

   always_comb begin
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      case (func3_i[1:0])
         2'b00: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{wdata_i[15:0]}};
         end
         default: begin
            be_o    = 4'b1111;
            wdata_o = wdata_i;
         end
      endcase
   end

   // Shift the addressed byte/halfword down to bit 0 before extending.
   always_comb begin
      lane    = rdata_i >> {addr_lo_i, 3'b000};
      rdata_o = lane;
      case (func3_i)
         F3_B:    rdata_o = {{24{lane[7]}}, lane[7:0]};
         F3_BU:   rdata_o = {24'h0, lane[7:0]};
         F3_H:    rdata_o = {{16{lane[15]}}, lane[15:0]};
         F3_HU:   rdata_o = {16'h0, lane[15:0]};
         default: rdata_o = lane;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store controller between execute and single-port data memory.
//   TIMEOUT              max cycles in REQ+WAIT before aborting with an error
//   clk, rst             clock, synchronous active-high reset
//   req_valid/op/func3/addr/wdata   request from execute
//   req_ready            controller idle and not in reset
//   stall                hold the pipeline while an access is pending
//   mem_req/we/addr/be/wdata        registered memory request (held until mem_gnt)
//   mem_gnt, mem_rvalid, mem_rdata  memory handshake and read return
//   resp_valid/rdata/err            one-cycle completion pulse with formatted load data
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [6:0]  req_op,
   input  logic [2:0]  req_func3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

   lsu_state_t  state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [2:0]  func3_q, func3_d;
   logic [1:0]  addr_lo_q, addr_lo_d;

   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_be_q, mem_be_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q, resp_err_d;

   logic        is_mem_op, is_store, req_ok, timed_out;
   logic [2:0]  al_func3;
   logic [1:0]  al_addr_lo;
   logic [3:0]  al_be;
   logic [31:0] al_wdata, al_rdata;

   assign is_mem_op = (req_op == OP_LOAD) || (req_op == OP_STORE);
   assign is_store  = (req_op == OP_STORE);
   assign req_ok    = f3_legal(is_store, req_func3) && addr_aligned(req_func3, req_addr[1:0]);
   assign timed_out = (cnt_q >= TO_LAST);

   // In IDLE the aligner decodes the incoming request; afterwards it works on
   // the latched access so the load lane is picked from the original address.
   assign al_func3   = (state_q == ST_IDLE) ? req_func3     : func3_q;
   assign al_addr_lo = (state_q == ST_IDLE) ? req_addr[1:0] : addr_lo_q;

   lsu_lane_align u_align (
      .func3_i  (al_func3),
      .addr_lo_i(al_addr_lo),
      .wdata_i  (req_wdata),
      .rdata_i  (mem_rdata),
      .be_o     (al_be),
      .wdata_o  (al_wdata),
      .rdata_o  (al_rdata)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      func3_d     = func3_q;
      addr_lo_d   = addr_lo_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      resp_err_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = 32'd0;
            if (req_valid && is_mem_op) begin
               func3_d   = req_func3;
               addr_lo_d = req_addr[1:0];
               if (req_ok) begin
                  state_d     = ST_REQ;
                  mem_we_d    = is_store;
                  mem_addr_d  = {req_addr[31:2], 2'b00};
                  mem_be_d    = al_be;
                  mem_wdata_d = al_wdata;
               end else begin
                  // Rejected at decode: the memory bus is never touched.
                  state_d    = ST_DONE;
                  resp_err_d = 1'b1;
               end
            end
         end
         ST_REQ: begin
            cnt_d = cnt_q + 32'd1;
            // A grant in the timeout cycle still completes the request.
            if (mem_gnt) begin
               state_d = mem_we_q ? ST_DONE : ST_WAIT;
            end else if (timed_out) begin
               state_d    = ST_DONE;
               resp_err_d = 1'b1;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + 32'd1;
            if (mem_rvalid) begin
               state_d = ST_DONE;
            end else if (timed_out) begin
               state_d    = ST_DONE;
               resp_err_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 32'd0;
         end
      endcase

      mem_req_d    = (state_d == ST_REQ);
      resp_valid_d = (state_d == ST_DONE);
      resp_rdata_d = resp_rdata_q;
      if (state_d == ST_DONE) begin
         resp_rdata_d = (state_q == ST_WAIT && mem_rvalid) ? al_rdata : 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 32'd0;
         func3_q      <= 3'd0;
         addr_lo_q    <= 2'd0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= 32'd0;
         mem_be_q     <= 4'd0;
         mem_wdata_q  <= 32'd0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         func3_q      <= func3_d;
         addr_lo_q    <= addr_lo_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
      end
   end

   assign req_ready  = (state_q == ST_IDLE) && !rst;
   // Low in DONE so the pipeline advances together with the result.
   assign stall      = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                       ((state_q == ST_IDLE) && req_valid && is_mem_op);
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_be     = mem_be_q;
   assign mem_wdata  = mem_wdata_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed stimulus pushes expected
// responses into a scoreboard queue; a monitor pops them on resp_valid.
module tb_lsu_mem_ctrl;
   import lsu_pkg::*;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst, req_valid;
   logic [6:0]  req_op;
   logic [2:0]  req_func3;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, stall;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_op(req_op), .req_func3(req_func3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        err;
      int          at;
   } exp_t;

   exp_t sb[$];
   int   cyc   = 0;
   int   acc   = 0;
   int   n_vec = 0;
   int   n_mis = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: pops one expectation per resp_valid; a response that does not
   // arrive by its expected cycle is reported as missing.
   always @(negedge clk) begin
      exp_t e;
      if (resp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_mis++;
            $display("FAIL unexpected_resp: resp_valid=1 at cycle %0d, expected none", cyc);
         end else begin
            e = sb.pop_front();
            chk({e.tag, "_rdata"}, resp_rdata, e.rdata);
            chk({e.tag, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
            chk({e.tag, "_cycle"}, cyc, e.at);
         end
      end else if (sb.size() != 0 && cyc > sb[0].at) begin
         e = sb.pop_front();
         n_vec++;
         n_mis++;
         $display("FAIL %s_missing: no resp_valid by cycle %0d, expected at %0d", e.tag, cyc, e.at);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // k = cycle number after the accept edge (cycle 1 follows the accept edge).
   task automatic push(input string tag, input logic [31:0] rd, input logic err, input int k);
      exp_t e;
      e.tag   = tag;
      e.rdata = rd;
      e.err   = err;
      e.at    = acc + k - 1;
      sb.push_back(e);
   endtask

   task automatic accept(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
      req_valid = 1'b1;
      req_op    = op;
      req_func3 = f3;
      req_addr  = addr;
      req_wdata = wd;
      #1;
      chk({tag, "_stall_accept"}, {31'd0, stall}, 32'd1);
      tick();
      acc       = cyc;
      req_valid = 1'b0;
      req_op    = 7'd0;
      req_func3 = 3'd0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
   endtask

   task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int gnt_dly,
                           input logic [31:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wd);
      accept(tag, OP_STORE, f3, addr, wd);
      push(tag, 32'd0, 1'b0, gnt_dly + 2);
      chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
      chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd1);
      chk({tag, "_mem_addr"}, mem_addr, exp_addr);
      chk({tag, "_mem_be"}, {28'd0, mem_be}, {28'd0, exp_be});
      chk({tag, "_mem_wdata"}, mem_wdata, exp_wd);
      repeat (gnt_dly) begin
         chk({tag, "_stall_req"}, {31'd0, stall}, 32'd1);
         tick();
      end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk({tag, "_mem_req_done"}, {31'd0, mem_req}, 32'd0);
      chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
      tick();
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rd, input int gnt_dly,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_rd);
      accept(tag, OP_LOAD, f3, addr, 32'h0);
      push(tag, exp_rd, 1'b0, gnt_dly + 3);
      chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
      chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, exp_addr);
      chk({tag, "_mem_be"}, {28'd0, mem_be}, {28'd0, exp_be});
      repeat (gnt_dly) begin
         chk({tag, "_stall_req"}, {31'd0, stall}, 32'd1);
         tick();
      end
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk({tag, "_mem_req_wait"}, {31'd0, mem_req}, 32'd0);
      chk({tag, "_stall_wait"}, {31'd0, stall}, 32'd1);
      mem_rvalid = 1'b1;
      mem_rdata  = rd;
      tick();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
      tick();
   endtask

   task automatic do_err(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr);
      accept(tag, op, f3, addr, 32'h12345678);
      push(tag, 32'd0, 1'b1, 1);
      chk({tag, "_no_mem_req"}, {31'd0, mem_req}, 32'd0);
      chk({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
      tick();
      chk({tag, "_no_mem_req_after"}, {31'd0, mem_req}, 32'd0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd0);
      chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
      chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
      chk({tag, "_mem_addr"}, mem_addr, 32'd0);
      chk({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
      chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
      chk({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
      chk({tag, "_stall"}, {31'd0, stall}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_op     = 7'd0;
      req_func3  = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;
      repeat (3) tick();
      chk_reset_outputs("reset");
      rst = 1'b0;
      tick();
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);

      // Non-memory opcode is ignored.
      req_valid = 1'b1;
      req_op    = 7'b0110011;
      req_addr  = 32'h3;
      #1;
      chk("alu_op_stall", {31'd0, stall}, 32'd0);
      tick();
      req_valid = 1'b0;
      req_op    = 7'd0;
      chk("alu_op_mem_req", {31'd0, mem_req}, 32'd0);
      chk("alu_op_idle", {31'd0, req_ready}, 32'd1);

      do_store("sb", F3_B, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5);
      do_store("sh", F3_H, 32'h0000_6002, 32'h1234_ABCD, 1, 32'h0000_6000, 4'b1100, 32'hABCD_ABCD);
      do_load("lh", F3_H, 32'h0000_2002, 32'h8001_1234, 2, 32'h0000_2000, 4'b1100, 32'hFFFF_8001);
      do_load("lhu", F3_HU, 32'h0000_2002, 32'h8001_1234, 2, 32'h0000_2000, 4'b1100, 32'h0000_8001);
      do_load("lb", F3_B, 32'h0000_5001, 32'h1234_80FF, 0, 32'h0000_5000, 4'b0010, 32'hFFFF_FF80);
      do_load("lbu", F3_BU, 32'h0000_5001, 32'h1234_80FF, 0, 32'h0000_5000, 4'b0010, 32'h0000_0080);
      do_load("lw", F3_W, 32'h0000_7000, 32'hCAFE_F00D, 0, 32'h0000_7000, 4'b1111, 32'hCAFE_F00D);

      do_err("lw_misaligned", OP_LOAD, F3_W, 32'h0000_3001);
      do_err("ld_f3_011", OP_LOAD, 3'b011, 32'h0000_3000);
      do_err("sh_misaligned", OP_STORE, F3_H, 32'h0000_0011);
      do_err("st_f3_100", OP_STORE, F3_BU, 32'h0000_0000);

      // Grant arriving in the timeout cycle still completes without error.
      do_store("sw_gnt_at_to", F3_W, 32'h0000_0900, 32'h1122_3344, TO - 1, 32'h0000_0900, 4'b1111, 32'h1122_3344);
      do_load("lw_gnt_at_to", F3_W, 32'h0000_0800, 32'h0BAD_F00D, TO - 1, 32'h0000_0800, 4'b1111, 32'h0BAD_F00D);

      // Load granted but never returned: error after TO cycles in REQ+WAIT.
      accept("lw_timeout", OP_LOAD, F3_W, 32'h0000_0100, 32'h0);
      push("lw_timeout", 32'd0, 1'b1, TO + 1);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      repeat (TO) tick();
      chk("lw_timeout_idle", {31'd0, req_ready}, 32'd1);
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hFFFF_FFFF;
      tick();
      chk("stray_rvalid_1", {31'd0, resp_valid}, 32'd0);
      tick();
      chk("stray_rvalid_2", {31'd0, resp_valid}, 32'd0);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'd0;

      // Store never granted: mem_req held until the timeout cycle, then dropped.
      accept("sw_timeout", OP_STORE, F3_W, 32'h0000_0200, 32'h5555_AAAA);
      push("sw_timeout", 32'd0, 1'b1, TO + 1);
      repeat (TO - 1) tick();
      chk("sw_timeout_req_held", {31'd0, mem_req}, 32'd1);
      tick();
      chk("sw_timeout_req_drop", {31'd0, mem_req}, 32'd0);
      chk("sw_timeout_stall", {31'd0, stall}, 32'd0);
      tick();

      // Reset in WAIT aborts silently.
      accept("lw_rst", OP_LOAD, F3_W, 32'h0000_0300, 32'h0);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      chk("lw_rst_stall_wait", {31'd0, stall}, 32'd1);
      rst = 1'b1;
      tick();
      chk_reset_outputs("rst_in_wait");
      rst = 1'b0;
      tick();
      chk("rst_release_ready", {31'd0, req_ready}, 32'd1);
      do_store("sw_after_rst", F3_W, 32'h0000_0040, 32'hDEAD_BEEF, 0, 32'h0000_0040, 4'b1111, 32'hDEAD_BEEF);

      repeat (3) tick();
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
